// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
//   Shared definitions for the synchronous FIFO family:
//     - default word / address widths and threshold levels
//     - read-mode encodings (standard registered read vs first-word-fall-through)
//     - small elaboration-time helpers for depth and default thresholds
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  // Default geometry: 16 entries of 8 bits.
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  // almost_empty asserts at or below this occupancy by default.
  localparam int DEFAULT_AE_LEVEL = 2;

  // almost_full sits this many entries below full by default.
  localparam int DEFAULT_AF_MARGIN = 2;

  // Read-mode encodings for the FWFT parameter.
  typedef enum int {
    FWFT_OFF = 0,  // rd_data registered, valid one cycle after an accepted read
    FWFT_ON  = 1   // rd_data shows the head word whenever the FIFO is not empty
  } read_mode_e;

  // Number of entries for a given address width.
  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Default almost_full level for a given address width.
  function automatic int default_af_level(input int addr_width);
    return depth_of(addr_width) - DEFAULT_AF_MARGIN;
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
//   DEPTH x DATA_WIDTH storage array for param_sync_fifo.
//   Write port is synchronous. The read port is either registered
//   (FWFT = FWFT_OFF) or asynchronous (FWFT = FWFT_ON).
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   async active-low reset (clears the registered read port only)
//   wr_en    in   write strobe, already qualified by the caller
//   wr_addr  in   ADDR_WIDTH  write address
//   wr_data  in   DATA_WIDTH  write word
//   rd_en    in   read strobe, already qualified (registered mode only)
//   rd_addr  in   ADDR_WIDTH  read address
//   rd_data  out  DATA_WIDTH  read word
// -----------------------------------------------------------------------------
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int FWFT       = FWFT_OFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  if (FWFT == FWFT_ON) begin : g_async_read
    // Head word is visible as soon as the pointers say it exists.
    assign rd_data = mem[rd_addr];
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] rd_q;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_q <= '0;
      end else if (rd_en) begin
        rd_q <= mem[rd_addr];
      end
    end

    assign rd_data = rd_q;
  end

endmodule : fifo_mem

// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
//   Single-clock FIFO with programmable depth, almost-full / almost-empty
//   thresholds, sticky overflow / underflow flags and a choice of standard
//   registered read or first-word-fall-through read.
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   async active-low reset
//   wr_en         in   write request (ignored while full -> overflow)
//   wr_data       in   DATA_WIDTH write word
//   rd_en         in   read request / pop (ignored while empty -> underflow)
//   rd_data       out  DATA_WIDTH read word
//   full          out  no free entry
//   empty         out  no stored entry
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  ADDR_WIDTH+1 occupancy, 0..DEPTH
//   overflow      out  sticky: a write was rejected
//   underflow     out  sticky: a read was rejected
//   err_clr       in   synchronous clear of overflow / underflow
// -----------------------------------------------------------------------------
module param_sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AF_LEVEL   = default_af_level(ADDR_WIDTH),
  parameter int AE_LEVEL   = DEFAULT_AE_LEVEL,
  parameter int FWFT       = FWFT_OFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int CNT_W = ADDR_WIDTH + 1;

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] AF_THR  = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_THR  = CNT_W'(AE_LEVEL);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic             overflow_q;
  logic             underflow_q;

  logic             wr_accept;
  logic             rd_accept;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // ---------------------------------------------------------------------------
  // Status: derived only from registered pointers and count.
  // ---------------------------------------------------------------------------
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  assign almost_full  = (count_q >= AF_THR);
  assign almost_empty = (count_q <= AE_THR);

  // A full FIFO can still be read and an empty one still written, so each
  // side is qualified only by its own status flag.
  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // ---------------------------------------------------------------------------
  // Pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy count
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns count_next and no latch is inferred.
    count_next = count_q;
    unique case ({wr_accept, rd_accept})
      2'b10:   count_next = count_q + CNT_ONE;
      2'b01:   count_next = count_q - CNT_ONE;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_next;
    end
  end

  assign count = count_q;

  // ---------------------------------------------------------------------------
  // Sticky error flags: a new error in the same cycle as err_clr keeps the
  // flag set, so the set term is tested first.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end else if (err_clr) begin
        overflow_q <= 1'b0;
      end

      if (rd_en && empty) begin
        underflow_q <= 1'b1;
      end else if (err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FWFT       (FWFT)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (mem_rd_data)
  );

  // In FWFT mode the array output is stale while empty (and undefined after
  // reset), so it is forced to zero until a word is actually present.
  if (FWFT == FWFT_ON) begin : g_fwft_out
    assign rd_data = empty ? '0 : mem_rd_data;
  end else begin : g_std_out
    assign rd_data = mem_rd_data;
  end

endmodule : param_sync_fifo

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width in bits (1..64).
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set DEPTH = 2**ADDR_WIDTH entries (2..10).
REQ-003 Parameter AF_LEVEL, default DEPTH-2, SHALL set the count at or above which almost_full asserts.
REQ-004 Parameter AE_LEVEL, default 2, SHALL set the count at or below which almost_empty asserts.
REQ-005 Parameter FWFT, default 0, SHALL select read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_data  input  DATA_WIDTH  write word.
REQ-010 rd_en  input  1  read request (FWFT: pop the displayed word).
REQ-011 rd_data  output  DATA_WIDTH  read word.
REQ-012 full, empty  output  1 each  occupancy status.
REQ-013 almost_full, almost_empty  output  1 each  threshold status.
REQ-014 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.
REQ-016 err_clr  input  1  synchronous clear of overflow and underflow.

Function
REQ-017 Write SHALL be accepted iff wr_en=1 and full=0; the word is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-018 Read SHALL be accepted iff rd_en=1 and empty=0; rd_ptr increments modulo DEPTH.
REQ-019 Pointers SHALL be ADDR_WIDTH+1 bits; full = (MSBs differ, lower bits equal); empty = (pointers equal).
REQ-020 count SHALL be registered: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-021 Simultaneous wr_en and rd_en when not full and not empty SHALL both be accepted, with count unchanged.
REQ-022 When full, simultaneous rd_en and wr_en SHALL accept the read, reject the write and set overflow.
REQ-023 When empty, simultaneous rd_en and wr_en SHALL accept the write, reject the read and set underflow (FWFT included).
REQ-024 Rejected wr_en SHALL set overflow; rejected rd_en SHALL set underflow; both flags hold until err_clr=1 or reset.
REQ-025 err_clr together with a new error in the same cycle SHALL leave the flag set (set wins).
REQ-026 FWFT=0: rd_data SHALL update one cycle after an accepted read and hold its value otherwise.
REQ-027 FWFT=1: rd_data SHALL present mem[rd_ptr] whenever empty=0; the first write into an empty FIFO SHALL be visible, with empty=0, on the cycle after the write edge.
REQ-028 full, empty, almost_full and almost_empty SHALL be derived from the registered pointers and count only, with no combinational path from wr_en or rd_en.
REQ-029 almost_full = (count >= AF_LEVEL); almost_empty = (count <= AE_LEVEL).
REQ-030 Wrap-around past DEPTH-1 SHALL preserve data order with no lost or duplicated word.

Reset
REQ-031 Asserting reset_n low SHALL immediately clear the pointers, count, overflow, underflow and rd_data, regardless of clk.
REQ-032 During reset: empty=1, almost_empty=1, full=0, almost_full=0 and count=0; memory contents are don't-care.
REQ-033 Reset asserted mid-operation SHALL discard all stored words; the first read after release returns the first post-reset write.

Structure
REQ-034 A shared package sync_fifo_pkg SHALL hold the default widths, threshold defaults and the FWFT mode encodings.
REQ-035 Storage SHALL be one sub-module, fifo_mem: a DEPTH x DATA_WIDTH array with a synchronous write port, plus a registered read port (FWFT=0) or an asynchronous read port (FWFT=1).
REQ-036 Pointer, count and flag logic SHALL reside in param_sync_fifo.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, default thresholds)
REQ-037 Write 0xAA, then read -> FWFT=0: rd_data=0xAA one cycle after the read; count goes 1 then 0.
REQ-038 Write 16 words 0x00..0x0F -> full=1 and count=16 after the 16th; almost_full=1 once count=14; a 17th write sets overflow and count stays 16.
REQ-039 Drain all 16 words -> data 0x00..0x0F in order, empty=1, almost_empty=1 once count=2; a further read sets underflow.
REQ-040 Fill 10 words, then 40 cycles of simultaneous write/read of an incrementing pattern -> count constant at 10, pointers wrap, output order exact.
REQ-041 FWFT=1: write 0x55 into an empty FIFO -> rd_data=0x55 and empty=0 on the next cycle, before any rd_en.
REQ-042 Pull reset_n low between clock edges with 5 words stored -> count=0 and empty=1 immediately; write 0x77 after release and read -> 0x77.
